// File: rtl/pep_mmacc_body_ram_mc_if.sv
// Bus bundle for the multi-channel body store: body writes, correction writes,
// read requests and the corrected-body output stream.
interface pep_mmacc_body_ram_mc_if #(
  parameter int CH_NB  = 2,
  parameter int PID_W  = 4,
  parameter int B_W    = 16,
  parameter int ERR_W  = 12,
  parameter int COEF_W = 8
);
  logic [CH_NB-1:0]            body_wr_vld;
  logic [CH_NB-1:0]            body_wr_rdy;
  logic [CH_NB-1:0][PID_W-1:0] body_wr_pid;
  logic [CH_NB-1:0][B_W-1:0]   body_wr_data;
  logic                        corr_wr_en;
  logic [PID_W-1:0]            corr_wr_pid;
  logic [ERR_W-1:0]            corr_wr_data;
  logic                        rd_vld;
  logic                        rd_rdy;
  logic [PID_W-1:0]            rd_pid;
  logic                        out_vld;
  logic                        out_rdy;
  logic [COEF_W-1:0]           out_data;

  modport master (
    output body_wr_vld, body_wr_pid, body_wr_data,
    output corr_wr_en, corr_wr_pid, corr_wr_data,
    output rd_vld, rd_pid, out_rdy,
    input  body_wr_rdy, rd_rdy, out_vld, out_data
  );

  modport slave (
    input  body_wr_vld, body_wr_pid, body_wr_data,
    input  corr_wr_en, corr_wr_pid, corr_wr_data,
    input  rd_vld, rd_pid, out_rdy,
    output body_wr_rdy, rd_rdy, out_vld, out_data
  );
endinterface

// File: rtl/pep_mmacc_body_ram_mc.sv
// Multi-channel LWE body store: round-robin body writes, per-PID correction
// accumulation, mean-compensated mod-switch readout, sweeping flush.
module pep_mmacc_body_ram_mc #(
  parameter int CH_NB      = 2,
  parameter int PID_W      = 4,
  parameter int DEPTH      = 16,
  parameter int B_W        = 16,
  parameter int ERR_W      = 12,
  parameter int CNT_TARGET = 4,
  parameter int COEF_W     = 8,
  parameter int MEAN_F     = 2,
  parameter int MEAN       = 2
) (
  input  logic clk,
  input  logic a_rst_n,
  input  logic corr_en_i,
  input  logic flush_i,
  output logic flush_busy_o,
  output logic err_rewrite_o,
  output logic err_corr_ovf_o,
  pep_mmacc_body_ram_mc_if.slave bus
);
  localparam int W     = B_W + MEAN_F;
  localparam int CNT_W = $clog2(CNT_TARGET + 1);
  localparam int CH_W  = (CH_NB > 1) ? $clog2(CH_NB) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CNT_TARGET);

  typedef enum logic {F_IDLE, F_CLEAR} fstate_e;

  typedef struct packed {
    logic [B_W-1:0]   b;
    logic [ERR_W-1:0] acc;
    logic             ce;
  } s1_t;

  fstate_e                     fstate_q, fstate_d;
  logic [PID_W-1:0]            faddr_q, faddr_d;
  logic [CH_W-1:0]             rr_q, rr_d;
  logic [DEPTH-1:0]            present_q;
  logic [DEPTH-1:0][CNT_W-1:0] cnt_q;
  logic [B_W-1:0]              b_mem   [DEPTH];
  logic [ERR_W-1:0]            acc_mem [DEPTH];
  logic                        s1_vld_q;
  s1_t                         s1_q;
  logic [COEF_W-1:0]           fifo_q  [2];
  logic                        wptr_q, rptr_q;
  logic [1:0]                  fcnt_q;
  logic                        err_rw_q, err_ovf_q;

  logic                        busy, found, wr_en;
  logic [CH_W-1:0]             gnt;
  logic [PID_W-1:0]            wr_pid;
  logic [B_W-1:0]              wr_data;
  logic [CNT_W-1:0]            corr_cnt;
  logic                        corr_ok, corr_ovf;
  logic                        rd_elig, rd_haz, rd_acc, pop, s1_adv;
  logic [ERR_W-1:0]            acc_eff;
  logic [W-1:0]                acc_sx, x;
  logic [COEF_W-1:0]           coef;

  // Flush sweep: one slot per cycle; a new pulse restarts from slot 0.
  always_comb begin
    fstate_d = fstate_q;
    faddr_d  = faddr_q;
    case (fstate_q)
      F_IDLE: if (flush_i) begin
        fstate_d = F_CLEAR;
        faddr_d  = '0;
      end
      F_CLEAR: begin
        if (flush_i)                            faddr_d  = '0;
        else if (faddr_q == PID_W'(DEPTH - 1)) fstate_d = F_IDLE;
        else                                    faddr_d  = faddr_q + PID_W'(1);
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  assign busy         = (fstate_q == F_CLEAR);
  assign flush_busy_o = busy;

  // rr_q holds the channel with highest priority next cycle.
  always_comb begin
    found = 1'b0;
    gnt   = rr_q;
    for (int k = 0; k < CH_NB; k++) begin
      if (!found && bus.body_wr_vld[(int'(rr_q) + k) % CH_NB]) begin
        found = 1'b1;
        gnt   = CH_W'((int'(rr_q) + k) % CH_NB);
      end
    end
  end

  assign wr_en   = found & ~busy;
  assign wr_pid  = bus.body_wr_pid[gnt];
  assign wr_data = bus.body_wr_data[gnt];
  assign rr_d    = (gnt == CH_W'(CH_NB - 1)) ? '0 : gnt + CH_W'(1);

  always_comb begin
    bus.body_wr_rdy = '0;
    if (wr_en) bus.body_wr_rdy[gnt] = 1'b1;
  end

  assign corr_cnt = cnt_q[bus.corr_wr_pid];
  assign corr_ok  = bus.corr_wr_en & (corr_cnt != CNT_FULL);
  assign corr_ovf = bus.corr_wr_en & (corr_cnt == CNT_FULL);

  // A read never races a write to its own PID: the write goes first.
  assign rd_elig = present_q[bus.rd_pid] & (~corr_en_i | (cnt_q[bus.rd_pid] == CNT_FULL));
  assign rd_haz  = (wr_en & (wr_pid == bus.rd_pid)) |
                   (bus.corr_wr_en & (bus.corr_wr_pid == bus.rd_pid));
  assign pop     = bus.out_vld & bus.out_rdy;
  assign s1_adv  = s1_vld_q & ((fcnt_q != 2'd2) | pop);
  assign bus.rd_rdy = rd_elig & (~s1_vld_q | s1_adv) & ~busy & ~rd_haz;
  assign rd_acc  = bus.rd_vld & bus.rd_rdy;

  // x = 4b - 2*acc style mean compensation, then round to the top COEF_W bits.
  assign acc_eff = s1_q.ce ? s1_q.acc : '0;
  assign acc_sx  = {{(W-ERR_W){acc_eff[ERR_W-1]}}, acc_eff};
  assign x       = {s1_q.b, {MEAN_F{1'b0}}} - acc_sx * W'(MEAN);
  assign coef    = x[W-1 -: COEF_W] + COEF_W'(x[W-1-COEF_W]);

  assign bus.out_vld  = (fcnt_q != 2'd0);
  assign bus.out_data = fifo_q[rptr_q];
  assign err_rewrite_o  = err_rw_q;
  assign err_corr_ovf_o = err_ovf_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      fstate_q  <= F_IDLE;
      faddr_q   <= '0;
      rr_q      <= '0;
      present_q <= '0;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      fcnt_q    <= '0;
      err_rw_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      fstate_q <= fstate_d;
      faddr_q  <= faddr_d;
      if (wr_en) begin
        rr_q              <= rr_d;
        present_q[wr_pid] <= 1'b1;
      end
      if (corr_ok) cnt_q[bus.corr_wr_pid] <= corr_cnt + CNT_W'(1);
      if (rd_acc) begin
        present_q[bus.rd_pid] <= 1'b0;
        cnt_q[bus.rd_pid]     <= '0;
      end
      if (busy) begin
        present_q[faddr_q] <= 1'b0;
        cnt_q[faddr_q]     <= '0;
      end
      s1_vld_q <= rd_acc | (s1_vld_q & ~s1_adv);
      if (rd_acc) begin
        s1_q.b   <= b_mem[bus.rd_pid];
        s1_q.acc <= acc_mem[bus.rd_pid];
        s1_q.ce  <= corr_en_i;
      end
      if (s1_adv) wptr_q <= ~wptr_q;
      if (pop)    rptr_q <= ~rptr_q;
      fcnt_q <= fcnt_q + {1'b0, s1_adv} - {1'b0, pop};
      if (flush_i)                          err_rw_q  <= 1'b0;
      else if (wr_en && present_q[wr_pid]) err_rw_q  <= 1'b1;
      if (flush_i)                          err_ovf_q <= 1'b0;
      else if (corr_ovf)                    err_ovf_q <= 1'b1;
    end
  end

  // Storage arrays need no reset: presence and counts gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) b_mem[wr_pid] <= wr_data;
    if (corr_ok)
      acc_mem[bus.corr_wr_pid] <= (corr_cnt == '0) ? bus.corr_wr_data
                                                   : acc_mem[bus.corr_wr_pid] + bus.corr_wr_data;
    if (s1_adv) fifo_q[wptr_q] <= coef;
  end
endmodule

// File: tb/tb_pep_mmacc_body_ram_mc.sv
// Randomized bench for pep_mmacc_body_ram_mc against a per-PID reference model.
module tb_pep_mmacc_body_ram_mc;
  localparam int CH_NB = 2, PID_W = 4, DEPTH = 16, B_W = 16, ERR_W = 12;
  localparam int CNT_TARGET = 4, COEF_W = 8, MEAN_F = 2, MEAN = 2;
  localparam int W = B_W + MEAN_F;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic corr_en = 1'b0, flush = 1'b0;
  logic flush_busy, err_rw, err_ovf;
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   rand_rdy = 1'b0;

  int m_present [DEPTH];
  int m_b       [DEPTH];
  int m_cnt     [DEPTH];
  int m_acc     [DEPTH];
  logic [COEF_W-1:0] exp_q[$];
  logic [COEF_W-1:0] got_q[$];

  pep_mmacc_body_ram_mc_if #(.CH_NB(CH_NB), .PID_W(PID_W), .B_W(B_W),
                             .ERR_W(ERR_W), .COEF_W(COEF_W)) ifc();

  pep_mmacc_body_ram_mc #(.CH_NB(CH_NB), .PID_W(PID_W), .DEPTH(DEPTH), .B_W(B_W),
    .ERR_W(ERR_W), .CNT_TARGET(CNT_TARGET), .COEF_W(COEF_W), .MEAN_F(MEAN_F),
    .MEAN(MEAN)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .corr_en_i(corr_en), .flush_i(flush),
    .flush_busy_o(flush_busy), .err_rewrite_o(err_rw), .err_corr_ovf_o(err_ovf),
    .bus(ifc.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (a_rst_n && ifc.out_vld && ifc.out_rdy) got_q.push_back(ifc.out_data);

  always @(posedge clk)
    if (rand_rdy) begin
      #1;
      ifc.out_rdy = 1'($urandom_range(0, 1));
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output: round(x / 2^(W-COEF_W)) mod 2^COEF_W, x = 4b - MEAN*acc mod 2^W.
  function automatic int ref_out(int b, int acc, bit ce);
    longint a, x;
    a = ce ? longint'(acc) : 0;
    if (a >= (longint'(1) << (ERR_W - 1))) a -= (longint'(1) << ERR_W);
    x = longint'(b) * (longint'(1) << MEAN_F) - a * MEAN;
    x = x & ((longint'(1) << W) - 1);
    return int'(((x + (longint'(1) << (W - COEF_W - 1))) >> (W - COEF_W)) & ((1 << COEF_W) - 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_rst_n = 1'b0;
    ifc.body_wr_vld = '0; ifc.body_wr_pid = '0; ifc.body_wr_data = '0;
    ifc.corr_wr_en = 1'b0; ifc.corr_wr_pid = '0; ifc.corr_wr_data = '0;
    ifc.rd_vld = 1'b0; ifc.rd_pid = '0; ifc.out_rdy = 1'b1;
    flush = 1'b0; corr_en = 1'b0;
    step(); step();
    a_rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_present[i] = 0; m_b[i] = 0; m_cnt[i] = 0; m_acc[i] = 0;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic wr_body(input int ch, input int pid, input int data, output int wcyc);
    bit ok = 1'b0;
    wcyc = -1;
    ifc.body_wr_vld[ch]  = 1'b1;
    ifc.body_wr_pid[ch]  = PID_W'(pid);
    ifc.body_wr_data[ch] = B_W'(data);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ifc.body_wr_rdy[ch]) begin ok = 1'b1; wcyc = cyc; end
      step();
    end
    ifc.body_wr_vld[ch] = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wr_body_grant: ch%0d pid %0d got no ready, required a grant", ch, pid);
    end else begin
      m_present[pid] = 1; m_b[pid] = data & 16'hFFFF;
    end
  endtask

  task automatic cw(input int pid, input int data);
    ifc.corr_wr_en = 1'b1; ifc.corr_wr_pid = PID_W'(pid); ifc.corr_wr_data = ERR_W'(data);
    if (m_cnt[pid] != CNT_TARGET) begin
      m_acc[pid] = (m_cnt[pid] == 0) ? (data & 12'hFFF) : ((m_acc[pid] + data) & 12'hFFF);
      m_cnt[pid]++;
    end
    step();
    ifc.corr_wr_en = 1'b0;
  endtask

  task automatic do_read(input int pid, output int acyc);
    bit ok = 1'b0;
    acyc = -1;
    ifc.rd_vld = 1'b1; ifc.rd_pid = PID_W'(pid);
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ifc.rd_rdy) begin
        ok = 1'b1; acyc = cyc;
        exp_q.push_back(COEF_W'(ref_out(m_b[pid], m_acc[pid], corr_en)));
        m_present[pid] = 0; m_cnt[pid] = 0;
      end
      step();
    end
    ifc.rd_vld = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rd_accept: pid %0d never accepted, required acceptance", pid);
    end
  endtask

  task automatic drain(output bit to);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= exp_q.size()) begin to = 1'b0; break; end
      step();
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    do_reset();
    ifc.rd_vld = 1'b1; ifc.rd_pid = 4'd0;
    @(negedge clk);
    n_chk++;
    if ({flush_busy, err_rw, err_ovf, ifc.out_vld, ifc.rd_rdy, ifc.body_wr_rdy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {flush_busy, err_rw, err_ovf, ifc.out_vld, ifc.rd_rdy, ifc.body_wr_rdy});
    end
    step();
    ifc.rd_vld = 1'b0;
  endtask

  task automatic test_corr_read();
    int w, a;
    bit to;
    do_reset();
    corr_en = 1'b1;
    wr_body(0, 3, 16'h12E0, w);
    repeat (4) cw(3, 2);
    do_read(3, a);
    @(negedge clk);
    n_chk++;
    if (ifc.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL corr_latency_t1: out_vld got %b required 0", ifc.out_vld);
    end
    @(negedge clk);
    n_chk++;
    if (ifc.out_vld !== 1'b1 || ifc.out_data !== 8'h13 || cyc != a + 2) begin
      n_fail++;
      $display("FAIL corr_latency_t2: vld %b data %h cyc %0d, required vld 1 data 13 cyc %0d", ifc.out_vld, ifc.out_data, cyc, a + 2);
    end
    step();
    drain(to);
    n_chk++;
    if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL corr_read_out: %0d outputs, required 1 of %h", got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_bypass();
    int w, a;
    bit to;
    do_reset();
    corr_en = 1'b0;
    wr_body(1, 5, 16'hFFFF, w);
    do_read(5, a);
    drain(to);
    n_chk++;
    if (to || got_q.size() != 1 || got_q[0] !== 8'h00) begin
      n_fail++; $display("FAIL bypass_wrap: got %0d outputs first %h, required 1 output 00", got_q.size(), got_q.size() ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_rr();
    int n0 = 0, n1 = 0, k0 = 0, k1 = 0, a, d0, d1;
    logic [1:0] exp_r;
    bit to;
    do_reset();
    d0 = $urandom_range(0, 65535); d1 = $urandom_range(0, 65535);
    ifc.body_wr_pid[0] = 4'd8; ifc.body_wr_data[0] = B_W'(d0);
    ifc.body_wr_pid[1] = 4'd9; ifc.body_wr_data[1] = B_W'(d1);
    ifc.body_wr_vld = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_chk++;
      if (ifc.body_wr_rdy !== exp_r) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b required %b", c, ifc.body_wr_rdy, exp_r);
      end
      step();
      if (exp_r[0]) begin
        m_present[8 + 2*k0] = 1; m_b[8 + 2*k0] = d0; n0++; k0++;
        d0 = $urandom_range(0, 65535);
        ifc.body_wr_pid[0] = PID_W'(8 + 2*k0); ifc.body_wr_data[0] = B_W'(d0);
      end else begin
        m_present[9 + 2*k1] = 1; m_b[9 + 2*k1] = d1; n1++; k1++;
        d1 = $urandom_range(0, 65535);
        ifc.body_wr_pid[1] = PID_W'(9 + 2*k1); ifc.body_wr_data[1] = B_W'(d1);
      end
    end
    ifc.body_wr_vld = 2'b00;
    n_chk++;
    if (n0 != 3 || n1 != 3) begin
      n_fail++; $display("FAIL rr_counts: ch0 %0d ch1 %0d, required 3 and 3", n0, n1);
    end
    for (int p = 8; p < 14; p++) do_read(p, a);
    drain(to);
    n_chk++;
    if (to || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rr_out_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rr_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall_order();
    int w, a;
    bit to;
    do_reset();
    wr_body(0, 2, $urandom_range(0, 65535), w);
    ifc.rd_vld = 1'b1; ifc.rd_pid = 4'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (ifc.rd_rdy !== 1'b0 || ifc.out_vld !== 1'b0) begin
        n_fail++; $display("FAIL stall_absent[%0d]: rd_rdy %b out_vld %b, required 0 0", i, ifc.rd_rdy, ifc.out_vld);
      end
      step();
    end
    wr_body(1, 7, $urandom_range(0, 65535), w);
    do_read(7, a);
    n_chk++;
    if (a <= w) begin
      n_fail++; $display("FAIL stall_accept_cycle: accepted cycle %0d, required after %0d", a, w);
    end
    do_read(2, a);
    drain(to);
    n_chk++;
    if (to || got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      n_fail++; $display("FAIL stall_order: got %0d outputs, required %h then %h", got_q.size(), exp_q[0], exp_q[1]);
    end
  endtask

  task automatic test_err_flush();
    int w, a, busy_n = 0;
    bit to;
    do_reset();
    corr_en = 1'b1;
    wr_body(0, 1, $urandom_range(0, 65535), w);
    @(negedge clk);
    n_chk++;
    if (err_rw !== 1'b0) begin n_fail++; $display("FAIL err_rewrite_first: got %b required 0", err_rw); end
    step();
    wr_body(1, 1, $urandom_range(0, 65535), w);
    @(negedge clk);
    n_chk++;
    if (err_rw !== 1'b1) begin n_fail++; $display("FAIL err_rewrite_set: got %b required 1", err_rw); end
    step();
    repeat (4) cw(1, $urandom_range(0, 4095));
    @(negedge clk);
    n_chk++;
    if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf_early: got %b required 0", err_ovf); end
    step();
    cw(1, $urandom_range(1, 4095));
    @(negedge clk);
    n_chk++;
    if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL err_ovf_set: got %b required 1", err_ovf); end
    step();
    do_read(1, a);
    drain(to);
    n_chk++;
    if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL ovf_acc_kept: got %0d outputs, required one of %h", got_q.size(), exp_q[0]);
    end
    wr_body(0, 1, $urandom_range(0, 65535), w);
    flush = 1'b1;
    step();
    flush = 1'b0;
    ifc.body_wr_vld[0] = 1'b1; ifc.body_wr_pid[0] = 4'd4; ifc.body_wr_data[0] = 16'h1234;
    @(negedge clk);
    n_chk++;
    if (err_rw !== 1'b0 || err_ovf !== 1'b0) begin
      n_fail++; $display("FAIL flush_err_clear: got %b%b required 00", err_rw, err_ovf);
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (!flush_busy) break;
      busy_n++;
      n_chk++;
      if (ifc.body_wr_rdy !== 2'b00) begin
        n_fail++; $display("FAIL flush_wr_block: body_wr_rdy %b required 00", ifc.body_wr_rdy);
      end
      step();
    end
    step();
    ifc.body_wr_vld[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_present[i] = 0; m_cnt[i] = 0; end
    m_present[4] = 1; m_b[4] = 16'h1234;
    n_chk++;
    if (busy_n != DEPTH) begin n_fail++; $display("FAIL flush_busy_len: got %0d required %0d", busy_n, DEPTH); end
    corr_en = 1'b0;
    ifc.rd_vld = 1'b1; ifc.rd_pid = 4'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++;
      if (ifc.rd_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_rd_stall[%0d]: rd_rdy %b required 0", i, ifc.rd_rdy); end
      step();
    end
    ifc.rd_vld = 1'b0;
  endtask

  task automatic test_backpressure();
    int w, a, pidx = 0;
    int pids [4] = '{10, 11, 12, 13};
    bit to, acc;
    do_reset();
    for (int i = 0; i < 4; i++) wr_body(i % 2, pids[i], $urandom_range(0, 65535), w);
    ifc.out_rdy = 1'b0;
    ifc.rd_vld = 1'b1; ifc.rd_pid = PID_W'(pids[0]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = ifc.rd_rdy;
      if (acc) begin
        exp_q.push_back(COEF_W'(ref_out(m_b[pids[pidx]], 0, 1'b0)));
        m_present[pids[pidx]] = 0;
      end
      step();
      if (acc) begin
        pidx++;
        if (pidx < 4) ifc.rd_pid = PID_W'(pids[pidx]); else ifc.rd_vld = 1'b0;
      end
    end
    @(negedge clk);
    n_chk++;
    if (pidx != 3 || ifc.rd_rdy !== 1'b0 || ifc.out_vld !== 1'b1 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_full: accepted %0d rd_rdy %b out_vld %b outs %0d, required 3 0 1 0", pidx, ifc.rd_rdy, ifc.out_vld, got_q.size());
    end
    step();
    ifc.out_rdy = 1'b1;
    do_read(pids[3], a);
    drain(to);
    n_chk++;
    if (to || got_q.size() != 4) begin n_fail++; $display("FAIL bp_out_count: got %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int w, a;
    do_reset();
    wr_body(0, 6, $urandom_range(0, 65535), w);
    do_read(6, a);
    a_rst_n = 1'b0;
    #1;
    n_chk++;
    if (ifc.out_vld !== 1'b0 || flush_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async: out_vld %b flush_busy %b required 0 0", ifc.out_vld, flush_busy);
    end
    step();
    a_rst_n = 1'b1;
    ifc.rd_vld = 1'b1; ifc.rd_pid = 4'd6;
    repeat (4) step();
    @(negedge clk);
    n_chk++;
    if (ifc.out_vld !== 1'b0 || ifc.rd_rdy !== 1'b0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_discard: out_vld %b rd_rdy %b outs %0d required 0 0 0", ifc.out_vld, ifc.rd_rdy, got_q.size());
    end
    step();
    ifc.rd_vld = 1'b0;
  endtask

  task automatic test_random();
    int w, a, base, st, n;
    int p [4];
    bit ce, to;
    do_reset();
    for (int bt = 0; bt < 8; bt++) begin
      ce = 1'($urandom_range(0, 1));
      corr_en = ce;
      base = $urandom_range(0, 15);
      st = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) p[i] = (base + i*st) % DEPTH;
      for (int i = 0; i < 4; i++) wr_body($urandom_range(0, 1), p[i], $urandom_range(0, 65535), w);
      for (int i = 0; i < 4; i++) begin
        n = ce ? CNT_TARGET : $urandom_range(0, CNT_TARGET);
        repeat (n) cw(p[i], $urandom_range(0, 4095));
      end
      rand_rdy = 1'b1;
      for (int i = 3; i >= 0; i--) do_read(p[i], a);
      rand_rdy = 1'b0;
      step();
      ifc.out_rdy = 1'b1;
    end
    drain(to);
    n_chk++;
    if (to || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_out_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_corr_read();
    test_bypass();
    test_rr();
    test_stall_order();
    test_err_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
